// File: rtl/onion_gpio_irq_controller.sv
// Wishbone-attached GPIO block: output/enable registers, input synchroniser,
// per-pin edge/level interrupt detection with W1C status and a level IRQ line.
module onion_gpio_irq_controller #(
   parameter int          GPIO_WIDTH        = 32,
   parameter int          SYNC_STAGES       = 2,
   parameter logic [31:0] DEFAULT_REG_VALUE = 32'hDEFFABAC
) (
   input  logic                  WBs_CLK_i,
   input  logic                  WBs_RST_i,
   input  logic [16:0]           WBs_ADR_i,
   input  logic                  WBs_CYC_i,
   input  logic                  WBs_STB_i,
   input  logic                  WBs_WE_i,
   input  logic [3:0]            WBs_BYTE_STB_i,
   input  logic [31:0]           WBs_DAT_i,
   output logic [31:0]           WBs_DAT_o,
   output logic                  WBs_ACK_o,
   inout  wire  [GPIO_WIDTH-1:0] GPIO_io,
   output logic                  GPIO_IRQ_o
);

   localparam int W = GPIO_WIDTH;

   localparam logic [7:0] A_IN     = 8'h00;
   localparam logic [7:0] A_OUT    = 8'h01;
   localparam logic [7:0] A_OE     = 8'h02;
   localparam logic [7:0] A_EN     = 8'h03;
   localparam logic [7:0] A_TYPE   = 8'h04;
   localparam logic [7:0] A_POL    = 8'h05;
   localparam logic [7:0] A_STATUS = 8'h06;
   localparam logic [7:0] A_SET    = 8'h07;
   localparam logic [7:0] A_CLR    = 8'h08;
   localparam logic [7:0] A_BOTH   = 8'h09;

   logic                         r_ack;
   logic [W-1:0]                 r_out, r_oe, r_en, r_type, r_pol, r_both, r_status;
   logic [SYNC_STAGES-1:0][W-1:0] r_sync;
   logic [W-1:0]                 r_prev;
   logic [2:0]                   r_hold;
   logic                         r_irq;

   logic [7:0]   w_sel;
   logic         w_wr;
   logic [31:0]  w_bmask, w_wd;
   logic [W-1:0] w_bm, w_d;
   logic [W-1:0] w_sync, w_rise, w_fall, w_edge, w_lvl, w_evt, w_set, w_clr;
   logic [31:0]  w_rdat;
   logic         w_unused;

   assign w_sel   = WBs_ADR_i[9:2];
   assign w_wr    = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~r_ack;
   assign w_bmask = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                     {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
   assign w_wd    = WBs_DAT_i & w_bmask;
   assign w_bm    = w_bmask[W-1:0];
   assign w_d     = w_wd[W-1:0];
   assign w_unused = ^{WBs_ADR_i[16:10], WBs_ADR_i[1:0], w_wd};

   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         r_ack <= 1'b0;
      end else begin
         r_ack <= WBs_CYC_i & WBs_STB_i & ~r_ack;
      end
   end

   assign WBs_ACK_o = r_ack;

   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         r_out  <= '0;
         r_oe   <= '0;
         r_en   <= '0;
         r_type <= '0;
         r_pol  <= '0;
         r_both <= '0;
      end else if (w_wr) begin
         case (w_sel)
            A_OUT:  r_out  <= (r_out  & ~w_bm) | w_d;
            A_OE:   r_oe   <= (r_oe   & ~w_bm) | w_d;
            A_EN:   r_en   <= (r_en   & ~w_bm) | w_d;
            A_TYPE: r_type <= (r_type & ~w_bm) | w_d;
            A_POL:  r_pol  <= (r_pol  & ~w_bm) | w_d;
            A_BOTH: r_both <= (r_both & ~w_bm) | w_d;
            A_SET:  r_out  <= r_out | w_d;
            A_CLR:  r_out  <= r_out & ~w_d;
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < W; g++) begin : g_pad
      assign GPIO_io[g] = r_oe[g] ? r_out[g] : 1'bz;
   end

   // r_hold masks events until the synchroniser and prev have been refilled
   // from real pin values after reset.
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         r_sync <= '0;
         r_prev <= '0;
         r_hold <= 3'(SYNC_STAGES + 1);
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], GPIO_io};
         r_prev <= w_sync;
         if (r_hold != 3'd0) r_hold <= r_hold - 3'd1;
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_prev;
   assign w_fall = ~w_sync & r_prev;
   assign w_edge = (r_both & (w_rise | w_fall)) |
                   (~r_both & ((r_pol & w_rise) | (~r_pol & w_fall)));
   assign w_lvl  = ~(w_sync ^ r_pol);
   assign w_evt  = (r_type & w_edge) | (~r_type & w_lvl);
   assign w_set  = (r_hold == 3'd0) ? (w_evt & r_en) : '0;
   assign w_clr  = (w_wr && w_sel == A_STATUS) ? w_d : '0;

   // set has priority over a coincident W1C of the same bit
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_clr) | w_set;
         r_irq    <= |(r_status & r_en);
      end
   end

   assign GPIO_IRQ_o = r_irq;

   always_comb begin
      w_rdat = DEFAULT_REG_VALUE;
      case (w_sel)
         A_IN:     w_rdat = 32'(w_sync);
         A_OUT:    w_rdat = 32'(r_out);
         A_OE:     w_rdat = 32'(r_oe);
         A_EN:     w_rdat = 32'(r_en);
         A_TYPE:   w_rdat = 32'(r_type);
         A_POL:    w_rdat = 32'(r_pol);
         A_STATUS: w_rdat = 32'(r_status);
         A_SET:    w_rdat = 32'd0;
         A_CLR:    w_rdat = 32'd0;
         A_BOTH:   w_rdat = 32'(r_both);
         default:  w_rdat = DEFAULT_REG_VALUE;
      endcase
   end

   assign WBs_DAT_o = w_rdat;

endmodule
